uart_rx_ctrl: RTL and testbench

Receive-side bit controller of the UART, directly upstream of the serial-to-parallel register. It synchronises the asynchronous rx line, detects and qualifies the start bit on an oversampled baud tick, and samples each data bit at mid-bit. It drives the one-bit serial stream plus a single-cycle shift strobe into the shift register, then checks optional parity and the stop bit and reports frame completion and errors.

---
 rtl/uart_rx_ctrl.sv | 167 ++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive bit controller: synchronises rx, qualifies the start bit at mid-bit,
// strobes each mid-bit data sample into the shift register, then checks parity and stop.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic rx_clk,
    input  logic rst,
    input  logic enable,
    input  logic baud_tick,
    input  logic rx,
    output logic shift,
    output logic serial_out,
    output logic rx_busy,
    output logic frame_done,
    output logic framing_error,
    output logic parity_error
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
    localparam logic          P_ODD    = (PARITY_ODD != 0);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [1:0]    r_sync;
    state_t        r_state,     w_state;
    logic [TW-1:0] r_tick,      w_tick;
    logic [BW-1:0] r_bit,       w_bit;
    logic          r_armed,     w_armed;
    logic          r_par,       w_par;
    logic          r_perr_pend, w_perr_pend;
    logic          r_shift,     w_shift;
    logic          r_sout,      w_sout;
    logic          r_done,      w_done;
    logic          r_ferr,      w_ferr;
    logic          r_perr,      w_perr;
    logic          w_rx_s;

    assign w_rx_s = r_sync[1];

    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            r_sync      <= 2'b11;
            r_state     <= S_IDLE;
            r_tick      <= '0;
            r_bit       <= '0;
            r_armed     <= 1'b0;
            r_par       <= 1'b0;
            r_perr_pend <= 1'b0;
            r_shift     <= 1'b0;
            r_sout      <= 1'b1;
            r_done      <= 1'b0;
            r_ferr      <= 1'b0;
            r_perr      <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], rx};
            r_state     <= w_state;
            r_tick      <= w_tick;
            r_bit       <= w_bit;
            r_armed     <= w_armed;
            r_par       <= w_par;
            r_perr_pend <= w_perr_pend;
            r_shift     <= w_shift;
            r_sout      <= w_sout;
            r_done      <= w_done;
            r_ferr      <= w_ferr;
            r_perr      <= w_perr;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_tick      = r_tick;
        w_bit       = r_bit;
        w_armed     = r_armed;
        w_par       = r_par;
        w_perr_pend = r_perr_pend;
        w_shift     = 1'b0;
        w_sout      = r_sout;
        w_done      = 1'b0;
        w_ferr      = r_ferr;
        w_perr      = r_perr;
        if (!enable) begin
            w_state = S_IDLE;
            w_armed = 1'b0;
            w_tick  = '0;
            w_bit   = '0;
        end else if (baud_tick) begin
            case (r_state)
                // A falling edge only counts once the line has been seen idle-high.
                S_IDLE: begin
                    if (r_armed && !w_rx_s) begin
                        w_state = S_START;
                        w_tick  = '0;
                        w_armed = 1'b0;
                    end else if (w_rx_s) begin
                        w_armed = 1'b1;
                    end
                end
                S_START: begin
                    if (r_tick == TICK_MID) begin
                        w_tick = '0;
                        if (!w_rx_s) begin
                            w_state     = S_DATA;
                            w_bit       = '0;
                            w_par       = 1'b0;
                            w_perr_pend = 1'b0;
                        end else begin
                            w_state = S_IDLE;
                        end
                    end else begin
                        w_tick = r_tick + TW'(1);
                    end
                end
                S_DATA: begin
                    if (r_tick == TICK_END) begin
                        w_sout  = w_rx_s;
                        w_shift = 1'b1;
                        w_par   = r_par ^ w_rx_s;
                        w_tick  = '0;
                        w_bit   = r_bit + BW'(1);
                        if (r_bit == BIT_LAST)
                            w_state = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_tick = r_tick + TW'(1);
                    end
                end
                S_PARITY: begin
                    if (r_tick == TICK_END) begin
                        w_perr_pend = r_par ^ w_rx_s ^ P_ODD;
                        w_tick      = '0;
                        w_state     = S_STOP;
                    end else begin
                        w_tick = r_tick + TW'(1);
                    end
                end
                S_STOP: begin
                    if (r_tick == TICK_END) begin
                        w_done  = 1'b1;
                        w_ferr  = ~w_rx_s;
                        w_perr  = (PARITY_EN != 0) ? r_perr_pend : 1'b0;
                        w_tick  = '0;
                        w_armed = 1'b0;
                        w_state = S_IDLE;
                    end else begin
                        w_tick = r_tick + TW'(1);
                    end
                end
                default: w_state = S_IDLE;
            endcase
        end
    end

    assign shift         = r_shift;
    assign serial_out    = r_sout;
    assign rx_busy       = (r_state != S_IDLE);
    assign frame_done    = r_done;
    assign framing_error = r_ferr;
    assign parity_error  = r_perr;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: an 8N1 instance and an 8E1 instance, 4 clocks per baud tick.
module tb_uart_rx_ctrl;

    localparam int OS     = 16;
    localparam int TPB    = 4;
    localparam int BITCLK = OS * TPB;

    logic rx_clk = 1'b0;
    logic rst = 1'b1, enable = 1'b1, baud_tick = 1'b0, rx = 1'b1, rx_p = 1'b1;
    logic [1:0] tdiv = 2'd0;

    logic shift, serial_out, rx_busy, frame_done, framing_error, parity_error;
    logic shift_p, serial_out_p, rx_busy_p, frame_done_p, framing_error_p, parity_error_p;

    int n_chk = 0, n_fail = 0;
    int sh_cnt = 0, done_cnt = 0, shp_cnt = 0, donep_cnt = 0, cyc = 0;
    logic [7:0] cap = 8'h00, capp = 8'h00;
    int stamps[$];
    logic [7:0] frames[$];
    int tgt = 0;

    uart_rx_ctrl #(.DATA_WIDTH(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0)) dut (
        .rx_clk(rx_clk), .rst(rst), .enable(enable), .baud_tick(baud_tick), .rx(rx),
        .shift(shift), .serial_out(serial_out), .rx_busy(rx_busy), .frame_done(frame_done),
        .framing_error(framing_error), .parity_error(parity_error)
    );

    uart_rx_ctrl #(.DATA_WIDTH(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
        .rx_clk(rx_clk), .rst(rst), .enable(enable), .baud_tick(baud_tick), .rx(rx_p),
        .shift(shift_p), .serial_out(serial_out_p), .rx_busy(rx_busy_p), .frame_done(frame_done_p),
        .framing_error(framing_error_p), .parity_error(parity_error_p)
    );

    always #5 rx_clk = ~rx_clk;

    always @(negedge rx_clk) begin
        tdiv = tdiv + 2'd1;
        baud_tick = (tdiv == 2'd0);
    end

    always @(negedge rx_clk) begin
        cyc++;
        if (shift) begin
            sh_cnt++;
            cap = {serial_out, cap[7:1]};
            stamps.push_back(cyc);
        end
        if (frame_done) begin
            done_cnt++;
            frames.push_back(cap);
        end
        if (shift_p) begin
            shp_cnt++;
            capp = {serial_out_p, capp[7:1]};
        end
        if (frame_done_p) donep_cnt++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge rx_clk);
    endtask

    task automatic drive(input logic b, input int nbits);
        if (tgt == 0) rx = b; else rx_p = b;
        wclk(nbits * BITCLK);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_en, input logic par_b,
                              input logic stop_b);
        drive(1'b0, 1);
        for (int i = 0; i < 8; i++) drive(d[i], 1);
        if (par_en) drive(par_b, 1);
        drive(stop_b, 1);
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_shift"}, int'(shift), 0);
        chk({pfx, "_sout"},  int'(serial_out), 1);
        chk({pfx, "_busy"},  int'(rx_busy), 0);
        chk({pfx, "_done"},  int'(frame_done), 0);
        chk({pfx, "_ferr"},  int'(framing_error), 0);
        chk({pfx, "_perr"},  int'(parity_error), 0);
    endtask

    initial begin
        int sb, db, st, fs;
        rst = 1'b1;
        wclk(5);
        chk_reset("por");
        rst = 1'b0;
        drive(1'b1, 2);

        // 8N1 0xA5
        sb = sh_cnt; db = done_cnt; st = stamps.size();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 2);
        chk("a5_shifts", sh_cnt - sb, 8);
        chk("a5_data", int'(cap), 'hA5);
        chk("a5_spacing", stamps[st+7] - stamps[st], 7 * BITCLK);
        chk("a5_done", done_cnt - db, 1);
        chk("a5_ferr", int'(framing_error), 0);
        chk("a5_perr", int'(parity_error), 0);
        chk("a5_busy", int'(rx_busy), 0);

        // glitch shorter than half a bit
        sb = sh_cnt; db = done_cnt;
        rx = 1'b0;
        wclk(12);
        chk("fs_busy", int'(rx_busy), 1);
        wclk(4);
        rx = 1'b1;
        wclk(2 * BITCLK);
        chk("fs_idle", int'(rx_busy), 0);
        chk("fs_shifts", sh_cnt - sb, 0);
        chk("fs_done", done_cnt - db, 0);

        // low stop bit, then line stuck low
        sb = sh_cnt; db = done_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 3);
        chk("brk_idle", int'(rx_busy), 0);
        chk("brk_shifts", sh_cnt - sb, 8);
        chk("brk_data", int'(cap), 'h3C);
        chk("brk_done", done_cnt - db, 1);
        chk("brk_ferr", int'(framing_error), 1);
        drive(1'b1, 1);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 2);
        chk("rec_shifts", sh_cnt - sb, 16);
        chk("rec_data", int'(cap), 'h55);
        chk("rec_done", done_cnt - db, 2);
        chk("rec_ferr", int'(framing_error), 0);

        // even parity on 0x07
        tgt = 1;
        sb = shp_cnt; db = donep_cnt;
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 2);
        chk("par_ok_shifts", shp_cnt - sb, 8);
        chk("par_ok_data", int'(capp), 'h07);
        chk("par_ok_done", donep_cnt - db, 1);
        chk("par_ok_perr", int'(parity_error_p), 0);
        chk("par_ok_ferr", int'(framing_error_p), 0);
        send_frame(8'h07, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 2);
        chk("par_bad_done", donep_cnt - db, 2);
        chk("par_bad_perr", int'(parity_error_p), 1);
        tgt = 0;

        // reset after the third data shift
        sb = sh_cnt;
        drive(1'b0, 4);
        chk("rm_three", sh_cnt - sb, 3);
        chk("rm_sout", int'(serial_out), 0);
        rst = 1'b1;
        wclk(3);
        chk_reset("rm");
        rx = 1'b1;
        wclk(3);
        rst = 1'b0;
        drive(1'b1, 2);
        sb = sh_cnt; db = done_cnt;
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 2);
        chk("rm_shifts", sh_cnt - sb, 8);
        chk("rm_data", int'(cap), 'h81);
        chk("rm_done", done_cnt - db, 1);
        chk("rm_ferr", int'(framing_error), 0);

        // back-to-back frames, no idle gap
        sb = sh_cnt; db = done_cnt; fs = frames.size();
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
        send_frame(8'h00, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 2);
        chk("b2b_shifts", sh_cnt - sb, 16);
        chk("b2b_done", done_cnt - db, 2);
        chk("b2b_first", (frames.size() > fs) ? int'(frames[fs]) : -1, 'hFF);
        chk("b2b_second", (frames.size() > fs + 1) ? int'(frames[fs+1]) : -1, 'h00);
        chk("b2b_ferr", int'(framing_error), 0);

        // enable dropped partway through the second frame
        sb = sh_cnt;
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 4);
        chk("en_pre_shifts", sh_cnt - sb, 11);
        enable = 1'b0;
        sb = sh_cnt; db = done_cnt;
        drive(1'b0, 5);
        drive(1'b1, 2);
        chk("en_shifts", sh_cnt - sb, 0);
        chk("en_done", done_cnt - db, 0);
        chk("en_busy", int'(rx_busy), 0);
        chk("en_sout", int'(serial_out), 0);
        chk("en_ferr", int'(framing_error), 0);
        enable = 1'b1;
        drive(1'b1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
